multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Multi-cycle sequencer for the 16-bit, 4-bit-opcode accumulator CPU. It replaces single-cycle decode with an FSM of fetch, decode, execute and write-back phases. It drives the instruction-memory handshake, IR/PC load strobes, ALU command and register-file write enable. It also adds a fetch timeout, illegal-opcode reporting and a halt instruction.

Parameters:
DATA_W, 16, width of reg1_data (register-file read port 1).
TIMEOUT, 15, maximum FETCH cycles waiting for mem_ack before ERROR (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begins execution from IDLE; ignored in every other state.
mem_ack  in  1  instruction memory has data valid this cycle; ignored outside FETCH.
opcode  in  4  IR[15:12], valid from the cycle after ir_load.
reg1_data  in  DATA_W  register-file read port 1 (branch test operand).
mem_req  out  1  instruction fetch request.
ir_load  out  1  load IR from memory data this cycle.
pc_load  out  1  update PC at the next clock edge.
pc_sel  out  1  0 = PC+1, 1 = branch target; meaningful only with pc_load.
alu_com  out  3  ALU command.
w_en  out  1  register-file write enable.
busy  out  1  high in every state except IDLE and ERROR.
illegal  out  1  one-cycle pulse on an undefined opcode.
err  out  1  fetch timeout occurred; sticky until rst.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, ERROR. Reset state is IDLE.
- Reset values: all outputs 0, alu_com=0, timeout counter=0. Reset takes effect immediately, including mid-instruction.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1.
  - Counter clears on entry and increments each cycle without mem_ack.
  - mem_ack in any of the first TIMEOUT FETCH cycles: ir_load=1 in that cycle (combinational on mem_ack) -> DECODE.
  - No ack after TIMEOUT cycles -> ERROR.
- DECODE: combinational on opcode.
  - 1..8 (ALU ops): alu_com register loads opcode-1 (1->0 ... 8->7) -> EXEC.
  - 0 (NOP): pc_load=1, pc_sel=0 -> FETCH.
  - 12 (branch-if-zero): pc_load=1, pc_sel=(reg1_data==0) -> FETCH.
  - 15 (HALT): no strobes -> IDLE.
  - 9, 10, 11, 13, 14: illegal=1, pc_load=1, pc_sel=0 -> FETCH (executed as NOP).
- EXEC: alu_com held; no strobes -> WB.
- WB: w_en=1, pc_load=1, pc_sel=0 -> FETCH.
- alu_com: registered; changes only in DECODE for opcodes 1..8, otherwise holds its last value.
- w_en is asserted only in WB, so exactly once per ALU instruction; never for branch, NOP, HALT or illegal opcodes.
- pc_sel=0 whenever pc_load=0.
- ERROR: err=1, busy=0, all strobes 0. Only rst exits.
- Instruction latency, with ack in the first FETCH cycle:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - NOP, branch or illegal: 2 cycles.
  - Each extra wait cycle adds 1.
- start high while busy has no effect. mem_ack in FETCH's final allowed cycle is accepted and ERROR is not entered.

Test Plan:
- ALU op: reset, start=1, mem_ack=1 in first FETCH cycle, opcode=3 -> ir_load in cycle 1; alu_com=2 in EXEC; WB has w_en=1, pc_load=1, pc_sel=0; next cycle FETCH with mem_req=1.
- Branch: opcode=12, reg1_data=0x0000 -> DECODE has pc_load=1, pc_sel=1, w_en=0. Repeat with reg1_data=0x0001 -> pc_sel=0.
- Timeout: mem_ack low for 15 FETCH cycles -> ERROR, err=1, busy=0; start ignored; rst clears err. Separately, mem_ack on the 15th cycle -> DECODE, err=0.
- Illegal/NOP/HALT: opcode=10 -> illegal=1 for one cycle, pc_load=1, pc_sel=0, no w_en. opcode=0 -> same without illegal. opcode=15 -> IDLE, busy=0.
- Wait states: mem_ack delayed 3 cycles -> mem_req high for 4 cycles, ir_load only in the ack cycle, ALU instruction completes in 7 cycles.
- Reset mid-op: assert rst during EXEC of opcode=8 (alu_com=7) -> all outputs 0 and alu_com=0 before the next clock edge; after release, IDLE until start.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute/write-back sequencer for the
// 16-bit accumulator CPU, with fetch timeout, illegal-op and halt.
module multicycle_controller #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_ack,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] reg1_data,
  output logic              mem_req,
  output logic              ir_load,
  output logic              pc_load,
  output logic              pc_sel,
  output logic [2:0]        alu_com,
  output logic              w_en,
  output logic              busy,
  output logic              illegal,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ERROR
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    alu_com_q;
  logic [2:0]    alu_com_d;

  logic op_nop;
  logic op_alu;
  logic op_brz;
  logic op_halt;
  logic op_ill;
  logic brz_taken;
  logic fetch_last;

  // Opcode classes; everything not otherwise defined is illegal
  always_comb begin
    op_nop    = (opcode == 4'd0);
    op_alu    = (opcode >= 4'd1) && (opcode <= 4'd8);
    op_brz    = (opcode == 4'd12);
    op_halt   = (opcode == 4'd15);
    op_ill    = !(op_nop || op_alu || op_brz || op_halt);
    brz_taken = (reg1_data == '0);
    fetch_last = (cnt_q == CW'(TIMEOUT - 1));
  end

  // State, timeout counter and ALU command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      alu_com_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_com_q <= alu_com_d;
    end
  end

  // Next-state, counter and ALU command update
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    alu_com_d = alu_com_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (fetch_last) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          op_alu: begin
            alu_com_d = opcode[2:0] - 3'd1;
            state_d   = S_EXEC;
          end
          op_halt: state_d = S_IDLE;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_FETCH;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and status decoded from the current state
  always_comb begin
    mem_req = 1'b0;
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_sel  = 1'b0;
    w_en    = 1'b0;
    busy    = 1'b0;
    illegal = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        ir_load = mem_ack;
      end
      S_DECODE: begin
        busy = 1'b1;
        unique case (1'b1)
          op_alu:  ;
          op_halt: ;
          op_brz: begin
            pc_load = 1'b1;
            pc_sel  = brz_taken;
          end
          op_ill: begin
            illegal = 1'b1;
            pc_load = 1'b1;
          end
          default: pc_load = 1'b1;
        endcase
      end
      S_EXEC: busy = 1'b1;
      S_WB: begin
        busy    = 1'b1;
        w_en    = 1'b1;
        pc_load = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  assign alu_com = alu_com_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an
// instruction-level model of the expected per-cycle outputs.
module tb_multicycle_controller;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_ack;
  logic [3:0]  opcode;
  logic [15:0] reg1_data;
  logic        mem_req;
  logic        ir_load;
  logic        pc_load;
  logic        pc_sel;
  logic [2:0]  alu_com;
  logic        w_en;
  logic        busy;
  logic        illegal;
  logic        err;

  multicycle_controller #(
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_ack  (mem_ack),
    .opcode   (opcode),
    .reg1_data(reg1_data),
    .mem_req  (mem_req),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pc_sel   (pc_sel),
    .alu_com  (alu_com),
    .w_en     (w_en),
    .busy     (busy),
    .illegal  (illegal),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] m_alu;
  bit         m_idle;

  wire [11:0] obs = {mem_req, ir_load, pc_load, pc_sel, alu_com,
                     w_en, busy, illegal, err};

  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (req,ir,pl,ps,alu3,we,bsy,ill,err)",
               tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(
    input logic req, input logic ir, input logic pl, input logic ps,
    input logic [2:0] alu, input logic we, input logic bsy,
    input logic ill, input logic er);
    return {req, ir, pl, ps, alu, we, bsy, ill, er};
  endfunction

  // inputs are set at the falling edge; check, then move one cycle on
  task automatic step(input string tag, input logic [11:0] exp);
    #1;
    check(tag, obs, exp);
    @(negedge clk);
  endtask

  // asynchronous reset from mid-cycle; outputs must clear at once
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check(tag, obs, 12'h000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_alu  = 3'd0;
    m_idle = 1'b1;
    start = 1'b0;
    repeat (2) begin
      mem_ack = 1'($urandom);
      step("idle_hold", pk(0, 0, 0, 0, m_alu, 0, 0, 0, 0));
    end
  endtask

  // one instruction: w wait cycles before ack (w >= TO means timeout)
  task automatic run_instr(input logic [3:0] op, input int w,
                           input logic [15:0] r1, input bit rst_exec);
    bit ack;
    if (m_idle) begin
      start = 1'b1;
      mem_ack = 1'($urandom);
      step("idle_start", pk(0, 0, 0, 0, m_alu, 0, 0, 0, 0));
      m_idle = 1'b0;
    end
    for (int i = 0; i < TO; i++) begin
      ack = (i == w);
      start = 1'($urandom);
      mem_ack = ack;
      opcode = 4'($urandom);
      reg1_data = 16'($urandom);
      step("fetch", pk(1, ack, 0, 0, m_alu, 0, 1, 0, 0));
      if (ack) break;
    end
    if (w >= TO) begin
      repeat (3) begin
        start = 1'b1;
        mem_ack = 1'($urandom);
        step("error", pk(0, 0, 0, 0, m_alu, 0, 0, 0, 1));
      end
      do_reset("rst_error");
      return;
    end
    start = 1'($urandom);
    mem_ack = 1'($urandom);
    opcode = op;
    reg1_data = r1;
    if (op >= 4'd1 && op <= 4'd8) begin
      step("decode_alu", pk(0, 0, 0, 0, m_alu, 0, 1, 0, 0));
      m_alu = 3'(op - 4'd1);
      opcode = 4'($urandom);
      if (rst_exec) begin
        #1;
        check("exec_pre_rst", obs, pk(0, 0, 0, 0, m_alu, 0, 1, 0, 0));
        do_reset("rst_exec");
        return;
      end
      step("exec", pk(0, 0, 0, 0, m_alu, 0, 1, 0, 0));
      start = 1'($urandom);
      step("wb", pk(0, 0, 1, 0, m_alu, 1, 1, 0, 0));
    end else if (op == 4'd0) begin
      step("decode_nop", pk(0, 0, 1, 0, m_alu, 0, 1, 0, 0));
    end else if (op == 4'd12) begin
      step("decode_brz", pk(0, 0, 1, r1 == 16'd0, m_alu, 0, 1, 0, 0));
    end else if (op == 4'd15) begin
      step("decode_halt", pk(0, 0, 0, 0, m_alu, 0, 1, 0, 0));
      m_idle = 1'b1;
      start = 1'b0;
      step("halted", pk(0, 0, 0, 0, m_alu, 0, 0, 0, 0));
    end else begin
      step("decode_ill", pk(0, 0, 1, 0, m_alu, 0, 1, 1, 0));
    end
  endtask

  initial begin
    int w;
    rst = 1'b1;
    start = 1'b0;
    mem_ack = 1'b0;
    opcode = 4'd0;
    reg1_data = 16'd0;
    m_alu = 3'd0;
    m_idle = 1'b1;
    @(negedge clk);
    #1;
    check("reset", obs, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    run_instr(4'd3, 0, 16'h1234, 1'b0);
    run_instr(4'd12, 0, 16'h0000, 1'b0);
    run_instr(4'd12, 0, 16'h0001, 1'b0);
    run_instr(4'd10, 0, 16'h0000, 1'b0);
    run_instr(4'd0, 0, 16'h0000, 1'b0);
    run_instr(4'd15, 0, 16'h0000, 1'b0);
    run_instr(4'd5, 3, 16'h0000, 1'b0);
    run_instr(4'd7, TO - 1, 16'h0000, 1'b0);
    run_instr(4'd2, TO, 16'h0000, 1'b0);
    run_instr(4'd8, 0, 16'h0000, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) w = TO;
      else if ($urandom_range(0, 3) == 0) w = $urandom_range(0, TO - 1);
      else w = $urandom_range(0, 3);
      run_instr(4'($urandom_range(0, 15)), w,
                ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom),
                $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
